// File: rtl/bus_quota_arbiter.sv
// rtl/bus_quota_arbiter.sv - four-master round-robin bus arbiter with hold quota and turnaround gap
//
// Masters request with active-low req_ lines. Ownership moves in circular order
// after the current owner. A one-cycle GAP (all grants high, owner already showing
// the new index) separates owners so the bus mux select settles before the new
// grant is driven. An owner that keeps the bus for HOLD_MAX contended cycles is
// preempted, and preempt pulses for the GAP that follows.

module bus_quota_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       preempt
);

  typedef enum logic {
    ST_GRANT = 1'b0,
    ST_GAP   = 1'b1
  } state_t;

  // Last contended cycle an owner may keep the bus before it is preempted.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       owner_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;
  logic             preempt_nxt;

  logic [3:0]       req;
  logic [3:0]       owner_mask;
  logic             owner_req;
  logic             other_req;
  logic [1:0]       next_owner;
  logic [3:0]       grnt_n;

  // First requesting master strictly after o in circular order; o itself if none.
  function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] o);
    logic [1:0] pick;
    logic       found;
    logic [1:0] cand;
    pick  = o;
    found = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cand = o + 2'(i);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Request decode: active-high view of the request lines split into owner/others.
  always_comb begin
    req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    owner_mask = 4'b0001 << owner;
    owner_req  = |(req & owner_mask);
    other_req  = |(req & ~owner_mask);
    next_owner = rr_next(req, owner);
  end

  // Next-state logic: hold, count contention, preempt on quota, hand off on release.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    hold_cnt_nxt = hold_cnt;
    preempt_nxt  = 1'b0;
    case (state)
      ST_GRANT: begin
        if (owner_req) begin
          if (other_req && (hold_cnt == HOLD_LAST)) begin
            // Quota used up while someone else waits: force a round-robin handoff.
            owner_nxt    = next_owner;
            state_nxt    = ST_GAP;
            hold_cnt_nxt = '0;
            preempt_nxt  = 1'b1;
          end else if (other_req) begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
          end else begin
            // Uncontended cycles do not eat into the quota.
            hold_cnt_nxt = '0;
          end
        end else if (other_req) begin
          // Voluntary release is a plain handoff even if the quota ran out this cycle.
          owner_nxt    = next_owner;
          state_nxt    = ST_GAP;
          hold_cnt_nxt = '0;
        end else begin
          // Idle bus stays parked on the current owner with its grant low.
          hold_cnt_nxt = '0;
        end
      end
      ST_GAP: begin
        // Single turnaround cycle; the new owner is granted regardless of its request.
        state_nxt    = ST_GRANT;
        hold_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = ST_GRANT;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // State register with synchronous active-high reset to a bus parked on master 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_GRANT;
      owner    <= 2'd0;
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_cnt_nxt;
      preempt  <= preempt_nxt;
    end
  end

  // Grant decode from registered state: only the owner's grant is low, none during GAP.
  always_comb begin
    grnt_n = 4'b1111;
    if (state == ST_GRANT) begin
      grnt_n = ~(4'b0001 << owner);
    end
    m0_grnt_ = grnt_n[0];
    m1_grnt_ = grnt_n[1];
    m2_grnt_ = grnt_n[2];
    m3_grnt_ = grnt_n[3];
  end

endmodule

// File: tb/tb_bus_quota_arbiter.sv
// tb/tb_bus_quota_arbiter.sv - scoreboard testbench for bus_quota_arbiter

module tb_bus_quota_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_n = 4'b1111;

  logic [3:0] g16_n;
  logic [1:0] owner16;
  logic       preempt16;
  logic [3:0] g4_n;
  logic [1:0] owner4;
  logic       preempt4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         sel;
    logic [3:0] grnt_n;
    logic [1:0] owner;
    logic       preempt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  bus_quota_arbiter #(.HOLD_MAX(16), .CNT_W(5)) dut16 (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g16_n[0]), .m1_grnt_(g16_n[1]), .m2_grnt_(g16_n[2]), .m3_grnt_(g16_n[3]),
    .owner(owner16), .preempt(preempt16)
  );

  bus_quota_arbiter #(.HOLD_MAX(4), .CNT_W(5)) dut4 (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(g4_n[0]), .m1_grnt_(g4_n[1]), .m2_grnt_(g4_n[2]), .m3_grnt_(g4_n[3]),
    .owner(owner4), .preempt(preempt4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] gv(input logic [1:0] o);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << o);
  endfunction

  localparam logic [3:0] GAP_N = 4'b1111;

  // Drive one cycle of stimulus (r is active-high), push the expected post-edge
  // outputs, then pop and compare them against the selected instance.
  task automatic cycle(input string tag, input logic rst, input logic [3:0] r, input int sel,
                       input logic [3:0] eg, input logic [1:0] eo, input logic ep);
    exp_t e;
    exp_t got;
    logic [3:0] og;
    logic [1:0] oo;
    logic       op;
    e.sel = sel; e.grnt_n = eg; e.owner = eo; e.preempt = ep;
    exp_q.push_back(e);
    reset = rst;
    req_n = ~r;
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    if (got.sel == 4) begin
      og = g4_n;  oo = owner4;  op = preempt4;
    end else begin
      og = g16_n; oo = owner16; op = preempt16;
    end
    check($sformatf("%s_grnt", tag), {4'b0, og}, {4'b0, got.grnt_n});
    check($sformatf("%s_owner", tag), {6'b0, oo}, {6'b0, got.owner});
    check($sformatf("%s_preempt", tag), {7'b0, op}, {7'b0, got.preempt});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] cur;
    logic [1:0] nxt;

    // Reset state, then idle bus stays parked on master 0.
    cycle("rst", 1'b1, 4'b0000, 16, gv(2'd0), 2'd0, 1'b0);
    check("rst_hold", {3'b0, dut16.hold_cnt}, 8'd0);
    for (int i = 0; i < 10; i++) cycle("idle", 1'b0, 4'b0000, 16, gv(2'd0), 2'd0, 1'b0);

    // Request to an idle bus parked elsewhere: GAP then grant.
    cycle("req2_rst", 1'b1, 4'b0000, 16, gv(2'd0), 2'd0, 1'b0);
    cycle("req2_gap", 1'b0, 4'b0100, 16, GAP_N, 2'd2, 1'b0);
    cycle("req2_grant", 1'b0, 4'b0100, 16, gv(2'd2), 2'd2, 1'b0);
    cycle("req2_park", 1'b0, 4'b0000, 16, gv(2'd2), 2'd2, 1'b0);
    cycle("req2_zero_lat", 1'b0, 4'b0100, 16, gv(2'd2), 2'd2, 1'b0);

    // Quota preemption with HOLD_MAX=16: 16 contended grant cycles including the first.
    cycle("quota_rst", 1'b1, 4'b0000, 16, gv(2'd0), 2'd0, 1'b0);
    for (int i = 0; i < 15; i++) cycle("quota_hold", 1'b0, 4'b0011, 16, gv(2'd0), 2'd0, 1'b0);
    cycle("quota_gap", 1'b0, 4'b0011, 16, GAP_N, 2'd1, 1'b1);
    cycle("quota_new", 1'b0, 4'b0011, 16, gv(2'd1), 2'd1, 1'b0);

    // Full contention with HOLD_MAX=4: 0,1,2,3,0 with 4-cycle holds and preempting gaps.
    cycle("rr_rst", 1'b1, 4'b1111, 4, gv(2'd0), 2'd0, 1'b0);
    cur = 2'd0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) cycle("rr_hold", 1'b0, 4'b1111, 4, gv(cur), cur, 1'b0);
      nxt = cur + 2'd1;
      cycle("rr_gap", 1'b0, 4'b1111, 4, GAP_N, nxt, 1'b1);
      cur = nxt;
      cycle("rr_first", 1'b0, 4'b1111, 4, gv(cur), cur, 1'b0);
    end

    // Owner 3 releases with masters 0 and 2 waiting: wraps to 0, no preempt.
    cycle("rel3_rst", 1'b1, 4'b0000, 16, gv(2'd0), 2'd0, 1'b0);
    cycle("rel3_gap3", 1'b0, 4'b1000, 16, GAP_N, 2'd3, 1'b0);
    cycle("rel3_own3", 1'b0, 4'b1000, 16, gv(2'd3), 2'd3, 1'b0);
    cycle("rel3_gap0", 1'b0, 4'b0101, 16, GAP_N, 2'd0, 1'b0);
    cycle("rel3_own0", 1'b0, 4'b0101, 16, gv(2'd0), 2'd0, 1'b0);

    // Release on the same cycle the quota expires: plain handoff, preempt stays 0.
    cycle("simul_rst", 1'b1, 4'b0000, 4, gv(2'd0), 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("simul_hold", 1'b0, 4'b0011, 4, gv(2'd0), 2'd0, 1'b0);
    cycle("simul_gap", 1'b0, 4'b0010, 4, GAP_N, 2'd1, 1'b0);
    cycle("simul_own1", 1'b0, 4'b0000, 4, gv(2'd1), 2'd1, 1'b0);

    // New owner is granted after GAP even though it dropped its request.
    cycle("drop_rst", 1'b1, 4'b0000, 16, gv(2'd0), 2'd0, 1'b0);
    cycle("drop_gap", 1'b0, 4'b0010, 16, GAP_N, 2'd1, 1'b0);
    cycle("drop_own1", 1'b0, 4'b0000, 16, gv(2'd1), 2'd1, 1'b0);

    // Reset during GAP with owner 2 returns to the reset state.
    cycle("rstgap_rst", 1'b1, 4'b0000, 16, gv(2'd0), 2'd0, 1'b0);
    cycle("rstgap_gap", 1'b0, 4'b0100, 16, GAP_N, 2'd2, 1'b0);
    cycle("rstgap_after", 1'b1, 4'b0100, 16, gv(2'd0), 2'd0, 1'b0);
    check("rstgap_hold", {3'b0, dut16.hold_cnt}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
